// File: rtl/logic_exec_stage.sv
// Buffered valid/ready execution stage for the bitwise logic unit: FIFO plus output register.
// Optional LOGIC_EXEC_BYPASS_EN lets an op skip the empty FIFO straight into the output register.
module logic_exec_stage #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [2:0]               out_op,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [2:0]       op_mem [DEPTH];
  logic [WIDTH-1:0] a_mem  [DEPTH];
  logic [WIDTH-1:0] b_mem  [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       op_q;
  logic             zero_q;

  logic             out_free, push, pop, bypass, wr_en, load;
  logic [2:0]       src_op;
  logic [WIDTH-1:0] src_a, src_b, res;

  function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return ~(a | b);
      3'b100:  return ~(a & b);
      3'b101:  return ~(a ^ b);
      3'b110:  return ~a;
      default: return a;
    endcase
  endfunction

  always_comb begin
    out_free = !out_valid_q || out_ready;
    push     = in_valid && in_ready;
    pop      = (count_q != '0) && out_free;
`ifdef LOGIC_EXEC_BYPASS_EN
    bypass   = push && (count_q == '0) && out_free;
`else
    bypass   = 1'b0;
`endif
    wr_en    = push && !bypass;
    load     = pop || bypass;
    // Queue head has priority; the input only feeds the result when bypassing.
    src_op   = pop ? op_mem[rd_ptr_q] : in_op;
    src_a    = pop ? a_mem[rd_ptr_q]  : in_a;
    src_b    = pop ? b_mem[rd_ptr_q]  : in_b;
    res      = logic_fn(src_op, src_a, src_b);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      op_mem[wr_ptr_q] <= in_op;
      a_mem[wr_ptr_q]  <= in_a;
      b_mem[wr_ptr_q]  <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      op_q        <= 3'b000;
      zero_q      <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(wr_en) - CntW'(pop);
      if (load) begin
        out_valid_q <= 1'b1;
        result_q    <= res;
        op_q        <= src_op;
        zero_q      <= (res == '0);
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready   = rst_n && (count_q != CntW'(DEPTH));
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_op     = op_q;
  assign out_zero   = zero_q;
  assign count      = count_q;

endmodule
